// File: rtl/arm_cond_pkg.sv
// -----------------------------------------------------------------------------
// arm_cond_pkg
//   Shared constants for the ARM condition unit: condition-field encodings,
//   bit positions inside the NZCV flags word, and the FlagW write-select bits.
// -----------------------------------------------------------------------------
package arm_cond_pkg;

  // Instruction condition field Instr[31:28]
  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;
  localparam logic [3:0] COND_NV = 4'hF;

  // Bit positions in the {N,Z,C,V} flags word
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // FlagW select bits
  localparam int FLAGW_NZ = 1;
  localparam int FLAGW_CV = 0;

endpackage

// File: rtl/cond_check.sv
// -----------------------------------------------------------------------------
// cond_check
//   Purely combinational evaluation of the ARM condition field against the
//   current NZCV flags.
// Ports:
//   Cond   in  [3:0]  instruction condition field
//   Flags  in  [3:0]  architectural flags {N,Z,C,V}
//   CondEx out        condition passed
// -----------------------------------------------------------------------------
module cond_check
  import arm_cond_pkg::*;
(
  input  logic [3:0] Cond,
  input  logic [3:0] Flags,
  output logic       CondEx
);

  logic n, z, c, v;

  assign n = Flags[FLAG_N];
  assign z = Flags[FLAG_Z];
  assign c = Flags[FLAG_C];
  assign v = Flags[FLAG_V];

  always_comb begin
    // NOTE: default assignment first so every path drives CondEx; no latch.
    CondEx = 1'b0;
    case (Cond)
      COND_EQ: CondEx = z;
      COND_NE: CondEx = ~z;
      COND_CS: CondEx = c;
      COND_CC: CondEx = ~c;
      COND_MI: CondEx = n;
      COND_PL: CondEx = ~n;
      COND_VS: CondEx = v;
      COND_VC: CondEx = ~v;
      COND_HI: CondEx = c & ~z;
      COND_LS: CondEx = ~c | z;
      COND_GE: CondEx = (n == v);
      COND_LT: CondEx = (n != v);
      COND_GT: CondEx = ~z & (n == v);
      COND_LE: CondEx = z | (n != v);
      COND_AL: CondEx = 1'b1;
      default: CondEx = 1'b0;  // NV is reserved: never executes
    endcase
  end

endmodule

// File: rtl/cond_logic.sv
// -----------------------------------------------------------------------------
// cond_logic
//   ARM condition unit. Holds the NZCV flags register, evaluates the condition
//   field, gates PCSrc/RegWrite/MemWrite and keeps saturating counters of
//   taken branches and squashed (condition-failed) instructions.
// Ports:
//   clk, reset   clock and synchronous active-high reset
//   Stall        current instruction does not retire this cycle
//   Cond         condition field; ALUFlags {N,Z,C,V} from the ALU
//   FlagW        [1] write N,Z  [0] write C,V
//   PCS/RegW/MemW/NoWrite   decoder/PC-logic write requests
//   PCSrc/RegWrite/MemWrite gated write enables (combinational)
//   CondEx       condition passed on current Flags
//   Flags        architectural NZCV register
//   BrCount      retired instructions with PCSrc=1 (saturating)
//   SquashCount  retired instructions with CondEx=0 (saturating)
// -----------------------------------------------------------------------------
module cond_logic
  import arm_cond_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Stall,
  input  logic [3:0]       Cond,
  input  logic [3:0]       ALUFlags,
  input  logic [1:0]       FlagW,
  input  logic             PCS,
  input  logic             RegW,
  input  logic             MemW,
  input  logic             NoWrite,
  output logic             PCSrc,
  output logic             RegWrite,
  output logic             MemWrite,
  output logic             CondEx,
  output logic [3:0]       Flags,
  output logic [CNT_W-1:0] BrCount,
  output logic [CNT_W-1:0] SquashCount
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [3:0]       flags_q,  flags_d;
  logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
  logic [CNT_W-1:0] sq_cnt_q, sq_cnt_d;
  logic             en;

  // Condition is judged on the flags as they stood before this instruction.
  cond_check u_cond_check (
    .Cond   (Cond),
    .Flags  (flags_q),
    .CondEx (CondEx)
  );

  assign en       = CondEx & ~Stall;
  assign PCSrc    = PCS  & en;
  assign MemWrite = MemW & en;
  assign RegWrite = RegW & en & ~NoWrite;

  always_comb begin
    flags_d  = flags_q;
    br_cnt_d = br_cnt_q;
    sq_cnt_d = sq_cnt_q;

    // N,Z and C,V halves update independently.
    if (en && FlagW[FLAGW_NZ]) begin
      flags_d[FLAG_N] = ALUFlags[FLAG_N];
      flags_d[FLAG_Z] = ALUFlags[FLAG_Z];
    end
    if (en && FlagW[FLAGW_CV]) begin
      flags_d[FLAG_C] = ALUFlags[FLAG_C];
      flags_d[FLAG_V] = ALUFlags[FLAG_V];
    end

    // Counters hold at all-ones instead of wrapping.
    if (!Stall && PCSrc && br_cnt_q != CNT_MAX)
      br_cnt_d = br_cnt_q + CNT_W'(1);
    if (!Stall && !CondEx && sq_cnt_q != CNT_MAX)
      sq_cnt_d = sq_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      flags_q  <= 4'b0000;
      br_cnt_q <= '0;
      sq_cnt_q <= '0;
    end else begin
      flags_q  <= flags_d;
      br_cnt_q <= br_cnt_d;
      sq_cnt_q <= sq_cnt_d;
    end
  end

  assign Flags       = flags_q;
  assign BrCount     = br_cnt_q;
  assign SquashCount = sq_cnt_q;

endmodule

// File: tb/tb_cond_logic.sv
// -----------------------------------------------------------------------------
// tb_cond_logic
//   Self-checking bench for cond_logic: directed vector table, hand-written
//   reset/stall/saturation sequences, and randomized stimulus compared against
//   a behavioural model. A second instance with CNT_W=2 exercises saturation.
// -----------------------------------------------------------------------------
module tb_cond_logic;

  logic       clk;
  logic       reset;
  logic       Stall;
  logic [3:0] Cond;
  logic [3:0] ALUFlags;
  logic [1:0] FlagW;
  logic       PCS, RegW, MemW, NoWrite;

  logic        PCSrc, RegWrite, MemWrite, CondEx;
  logic [3:0]  Flags;
  logic [15:0] BrCount, SquashCount;

  logic        PCSrc2, RegWrite2, MemWrite2, CondEx2;
  logic [3:0]  Flags2;
  logic [1:0]  BrCount2, SquashCount2;

  int checks = 0;
  int errors = 0;

  cond_logic #(.CNT_W(16)) dut (
    .clk(clk), .reset(reset), .Stall(Stall), .Cond(Cond), .ALUFlags(ALUFlags),
    .FlagW(FlagW), .PCS(PCS), .RegW(RegW), .MemW(MemW), .NoWrite(NoWrite),
    .PCSrc(PCSrc), .RegWrite(RegWrite), .MemWrite(MemWrite), .CondEx(CondEx),
    .Flags(Flags), .BrCount(BrCount), .SquashCount(SquashCount)
  );

  cond_logic #(.CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .Stall(Stall), .Cond(Cond), .ALUFlags(ALUFlags),
    .FlagW(FlagW), .PCS(PCS), .RegW(RegW), .MemW(MemW), .NoWrite(NoWrite),
    .PCSrc(PCSrc2), .RegWrite(RegWrite2), .MemWrite(MemWrite2), .CondEx(CondEx2),
    .Flags(Flags2), .BrCount(BrCount2), .SquashCount(SquashCount2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic rst, input logic stall, input logic [3:0] cond,
                       input logic [3:0] alu, input logic [1:0] fw, input logic pcs,
                       input logic regw, input logic memw, input logic nowr);
    reset = rst; Stall = stall; Cond = cond; ALUFlags = alu; FlagW = fw;
    PCS = pcs; RegW = regw; MemW = memw; NoWrite = nowr;
  endtask

  function automatic int sat(input int v, input int maxv);
    return (v > maxv) ? maxv : v;
  endfunction

  // ---------------------------------------------------------------------------
  // Behavioural model: flags as separate booleans, counters as plain integers.
  // ---------------------------------------------------------------------------
  bit m_n, m_z, m_c, m_v;
  int m_br, m_sq;   // unbounded counts; each DUT width saturates them

  function automatic bit m_cond(input int c, input bit n, input bit z, input bit cf, input bit v);
    case (c)
      0:  return z;
      1:  return !z;
      2:  return cf;
      3:  return !cf;
      4:  return n;
      5:  return !n;
      6:  return v;
      7:  return !v;
      8:  return cf && !z;
      9:  return !cf || z;
      10: return n == v;
      11: return n != v;
      12: return !z && (n == v);
      13: return z || (n != v);
      14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // One model-checked cycle with the currently driven inputs.
  task automatic model_cycle();
    bit ce, en;
    @(negedge clk);
    ce = m_cond(int'(Cond), m_n, m_z, m_c, m_v);
    en = ce && !Stall;
    check("rnd_condex",   CondEx,   ce);
    check("rnd_pcsrc",    PCSrc,    PCS && en);
    check("rnd_regwrite", RegWrite, RegW && en && !NoWrite);
    check("rnd_memwrite", MemWrite, MemW && en);
    check("rnd_condex2",  CondEx2,  ce);
    if (reset) begin
      {m_n, m_z, m_c, m_v} = 4'b0000;
      m_br = 0; m_sq = 0;
    end else begin
      if (en && FlagW[1]) begin m_n = ALUFlags[3]; m_z = ALUFlags[2]; end
      if (en && FlagW[0]) begin m_c = ALUFlags[1]; m_v = ALUFlags[0]; end
      if (!Stall && PCS && en) m_br = sat(m_br + 1, 65535);
      if (!Stall && !ce)       m_sq = sat(m_sq + 1, 65535);
    end
    @(posedge clk); #1;
    check("rnd_flags",  Flags,        {m_n, m_z, m_c, m_v});
    check("rnd_br",     BrCount,      m_br);
    check("rnd_sq",     SquashCount,  m_sq);
    check("rnd_br2",    BrCount2,     sat(m_br, 3));
    check("rnd_sq2",    SquashCount2, sat(m_sq, 3));
  endtask

  // ---------------------------------------------------------------------------
  // Directed vector table
  // ---------------------------------------------------------------------------
  typedef struct {
    logic       stall;
    logic [3:0] cond;
    logic [3:0] alu;
    logic [1:0] fw;
    logic       pcs, regw, memw, nowr;
    logic       e_ce, e_pc, e_rw, e_mw;
    logic [3:0] e_flags;   // flags after the edge
    int         e_br, e_sq; // 16-bit counters after the edge
  } vec_t;

  vec_t tbl[12];

  initial begin
    // stall cond   alu      fw     pcs regw memw nowr  ce pc rw mw  flags  br sq
    tbl[0]  = '{1'b0, 4'hE, 4'b0100, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0100, 0, 0};
    tbl[1]  = '{1'b0, 4'h0, 4'b0000, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0100, 1, 0};
    tbl[2]  = '{1'b0, 4'h1, 4'b0000, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0100, 1, 1};
    tbl[3]  = '{1'b0, 4'hE, 4'b1011, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b1000, 1, 1};
    tbl[4]  = '{1'b0, 4'hE, 4'b0011, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b1011, 1, 1};
    tbl[5]  = '{1'b0, 4'hE, 4'b0001, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b1001, 1, 1};
    tbl[6]  = '{1'b0, 4'hA, 4'b0000, 2'b00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'b1001, 1, 1};
    tbl[7]  = '{1'b0, 4'hA, 4'b0000, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'b1001, 1, 1};
    tbl[8]  = '{1'b0, 4'hB, 4'b0000, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1001, 1, 2};
    tbl[9]  = '{1'b1, 4'hE, 4'b0110, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b1001, 1, 2};
    tbl[10] = '{1'b0, 4'hF, 4'b0110, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1001, 1, 3};
    tbl[11] = '{1'b0, 4'h8, 4'b0110, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1001, 1, 4};
  end

  initial begin
    drive(1'b0, 1'b0, 4'hE, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;

    // Reset wins over a flag write and a taken branch on the same edge.
    drive(1'b1, 1'b0, 4'hE, 4'hF, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    check("reset_flags", Flags, 4'b0000);
    check("reset_br",    BrCount, 0);
    check("reset_sq",    SquashCount, 0);
    check("reset_br2",   BrCount2, 0);

    for (int i = 0; i < 12; i++) begin
      drive(1'b0, tbl[i].stall, tbl[i].cond, tbl[i].alu, tbl[i].fw,
            tbl[i].pcs, tbl[i].regw, tbl[i].memw, tbl[i].nowr);
      @(negedge clk);
      check($sformatf("vec%0d_condex", i),   CondEx,   tbl[i].e_ce);
      check($sformatf("vec%0d_pcsrc", i),    PCSrc,    tbl[i].e_pc);
      check($sformatf("vec%0d_regwrite", i), RegWrite, tbl[i].e_rw);
      check($sformatf("vec%0d_memwrite", i), MemWrite, tbl[i].e_mw);
      @(posedge clk); #1;
      check($sformatf("vec%0d_flags", i), Flags,        tbl[i].e_flags);
      check($sformatf("vec%0d_br", i),    BrCount,      tbl[i].e_br);
      check($sformatf("vec%0d_sq", i),    SquashCount,  tbl[i].e_sq);
      check($sformatf("vec%0d_sq2", i),   SquashCount2, sat(tbl[i].e_sq, 3));
    end

    // Saturation: four taken branches from reset; 2-bit counter sticks at 11.
    drive(1'b1, 1'b0, 4'hE, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    for (int k = 1; k <= 4; k++) begin
      drive(1'b0, 1'b0, 4'hE, 4'h0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
      @(posedge clk); #1;
      check($sformatf("sat_br16_%0d", k), BrCount, k);
      check($sformatf("sat_br2_%0d", k),  BrCount2, (k > 3) ? 3 : k);
    end
    // Reserved NV never executes, even with PCS asserted.
    drive(1'b0, 1'b0, 4'hF, 4'h0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("nv_condex", CondEx, 1'b0);
    check("nv_pcsrc",  PCSrc,  1'b0);
    @(posedge clk); #1;
    check("nv_sq",     SquashCount, 1);
    check("nv_br2",    BrCount2, 3);

    // Randomized phase, starting from a reset so the model is in step.
    drive(1'b1, 1'b0, 4'hE, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    model_cycle();
    for (int r = 0; r < 400; r++) begin
      drive(($urandom_range(0, 99) < 3), ($urandom_range(0, 3) == 0),
            4'($urandom), 4'($urandom), 2'($urandom),
            1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      model_cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
